// File: rtl/exec_unit.sv
// Multi-cycle execute/write-back stage sitting beside the 8x16 register file.
// Optional iterative multiplier for opcode 111 is compiled in with `define EXEC_MUL_EN.
//
// state | meaning
// IDLE  | ready for a new instruction, fields latched on accept
// READ  | register file operands latched into A/B
// EXEC  | single-cycle ALU op computed into result and flags
// MUL   | 16 shift-add iterations (only with EXEC_MUL_EN)
// WB    | write port driven, flags committed at end of cycle
module exec_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [2:0]  opcode,
    input  logic [2:0]  rd,
    input  logic [2:0]  rs1,
    input  logic [2:0]  rs2,
    input  logic [7:0]  imm8,
    output logic [2:0]  rd_addr_a,
    output logic [2:0]  rd_addr_b,
    input  logic [15:0] d_out_a,
    input  logic [15:0] d_out_b,
    output logic        wr,
    output logic [2:0]  wr_addr,
    output logic [15:0] d_in,
    output logic        flag_z,
    output logic        flag_c,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        EXEC = 3'd2,
        MUL  = 3'd3,
        WB   = 3'd4
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_LDI = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    state_t      state_q, state_d;
    logic [2:0]  op_q, rd_q, rs1_q, rs2_q, wr_addr_q;
    logic [7:0]  imm_q;
    logic [15:0] a_q, b_q, result_q;
    logic        res_z_q, res_c_q, flag_z_q, flag_c_q;

    logic [16:0] sum17, diff17, shl17;
    logic [15:0] alu_res;
    logic        alu_c;
    logic        illegal;

`ifdef EXEC_MUL_EN
    logic [31:0] mcand_q, prod_q, prod_nxt;
    logic [15:0] mplier_q;
    logic [3:0]  cnt_q;

    assign prod_nxt = prod_q + (mplier_q[0] ? mcand_q : 32'h0);
    assign illegal  = 1'b0;
`else
    assign illegal  = (op_q == OP_MUL);
`endif

    assign sum17  = {1'b0, a_q} + {1'b0, b_q};
    assign diff17 = {1'b0, a_q} - {1'b0, b_q};
    // Bit 16 holds the last bit shifted out; it stays 0 for a zero shift amount.
    assign shl17  = {1'b0, a_q} << b_q[3:0];

    always_comb begin
        alu_res = 16'h0000;
        alu_c   = 1'b0;
        case (op_q)
            OP_ADD: begin alu_res = sum17[15:0];  alu_c = sum17[16];  end
            OP_SUB: begin alu_res = diff17[15:0]; alu_c = diff17[16]; end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_SHL: begin alu_res = shl17[15:0];  alu_c = shl17[16];  end
            OP_LDI: alu_res = {8'h00, imm_q};
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (instr_valid) state_d = READ;
            READ: begin
                state_d = EXEC;
`ifdef EXEC_MUL_EN
                if (op_q == OP_MUL) state_d = MUL;
`endif
            end
            EXEC: state_d = illegal ? IDLE : WB;
`ifdef EXEC_MUL_EN
            MUL:  if (cnt_q == 4'd0) state_d = WB;
`endif
            WB:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q      <= 3'd0;
            rd_q      <= 3'd0;
            rs1_q     <= 3'd0;
            rs2_q     <= 3'd0;
            imm_q     <= 8'h00;
            a_q       <= 16'h0000;
            b_q       <= 16'h0000;
            result_q  <= 16'h0000;
            res_z_q   <= 1'b0;
            res_c_q   <= 1'b0;
            wr_addr_q <= 3'd0;
            flag_z_q  <= 1'b0;
            flag_c_q  <= 1'b0;
`ifdef EXEC_MUL_EN
            mcand_q   <= 32'h0;
            prod_q    <= 32'h0;
            mplier_q  <= 16'h0;
            cnt_q     <= 4'd0;
`endif
        end else begin
            case (state_q)
                IDLE: if (instr_valid) begin
                    op_q  <= opcode;
                    rd_q  <= rd;
                    rs1_q <= rs1;
                    rs2_q <= rs2;
                    imm_q <= imm8;
                end
                READ: begin
                    a_q <= d_out_a;
                    b_q <= d_out_b;
`ifdef EXEC_MUL_EN
                    mcand_q  <= {16'h0000, d_out_a};
                    mplier_q <= d_out_b;
                    prod_q   <= 32'h0;
                    cnt_q    <= 4'd15;
`endif
                end
                EXEC: if (!illegal) begin
                    result_q  <= alu_res;
                    res_c_q   <= alu_c;
                    res_z_q   <= (alu_res == 16'h0000);
                    wr_addr_q <= rd_q;
                end
`ifdef EXEC_MUL_EN
                MUL: begin
                    prod_q   <= prod_nxt;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - 4'd1;
                    if (cnt_q == 4'd0) begin
                        result_q  <= prod_nxt[15:0];
                        res_c_q   <= |prod_nxt[31:16];
                        res_z_q   <= (prod_nxt[15:0] == 16'h0000);
                        wr_addr_q <= rd_q;
                    end
                end
`endif
                WB: begin
                    flag_z_q <= res_z_q;
                    flag_c_q <= res_c_q;
                end
                default: ;
            endcase
        end
    end

    assign instr_ready = (state_q == IDLE) & reset;
    assign wr          = (state_q == WB) & reset;
    assign err         = (state_q == EXEC) & illegal & reset;
    assign rd_addr_a   = rs1_q;
    assign rd_addr_b   = rs2_q;
    assign wr_addr     = wr_addr_q;
    assign d_in        = result_q;
    assign flag_z      = flag_z_q;
    assign flag_c      = flag_c_q;

endmodule
